ppu_cfg_rx: RTL and testbench

PPU_CFG_RX -- requirements
Module: ppu_cfg_rx

---
 rtl/ppu_cfg_rx.sv | 175 +++++++++++++++++
 tb/tb_ppu_cfg_rx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ppu_cfg_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ppu_cfg_rx
//  Description : Receives a burst of NBYTES configuration bytes from an
//                initiator over a strobe/ack handshake while sync is high,
//                then replays the stored set toward the pixel path as a
//                wrapping stb_o/ack_i stream once sync drops.
//  Revision    : 1.0 - initial release
// ============================================================================
module ppu_cfg_rx #(
  parameter int NBYTES = 10
) (
  input  logic       clk_pix,
  input  logic       rst_pix,
  input  logic       sync,
  input  logic [7:0] data_i,
  input  logic       stb_i,
  output logic       ack_o,
  output logic [7:0] data_o,
  output logic       stb_o,
  input  logic       ack_i,
  output logic       cfg_valid,
  output logic       load_err
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_LOAD   = 2'd1;
  localparam logic [1:0] c_DONE   = 2'd2;
  localparam logic [1:0] c_STREAM = 2'd3;

  localparam logic [3:0] c_LAST_IDX = 4'(NBYTES - 1);

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [3:0]          r_wr_ptr;
  logic [3:0]          r_rd_ptr;
  logic                r_ack;
  logic                r_stb;
  logic [7:0]          r_data;
  logic                r_cfg_valid;
  logic                r_load_err;
  logic [NBYTES*8-1:0] w_cfg_flat;

  logic                w_load_start;
  logic                w_accept;
  logic                w_last;
  logic                w_abort;
  logic                w_stream_start;
  logic                w_reload;
  logic                w_advance;
  logic [3:0]          w_rd_nxt;
  logic [7:0]          w_rd_byte;

  // State register
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; an abort in LOAD outranks a same-cycle final accept
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:   if (sync)        w_state_nxt = c_LOAD;
      c_LOAD: begin
        if (!sync)               w_state_nxt = c_IDLE;
        else if (w_last)         w_state_nxt = c_DONE;
      end
      c_DONE:   if (!sync)       w_state_nxt = c_STREAM;
      c_STREAM: if (sync)        w_state_nxt = c_LOAD;
      default:                   w_state_nxt = c_IDLE;
    endcase
  end

  // Per-state control strobes feeding the registered outputs and datapath
  always_comb begin
    w_load_start   = (r_state == c_IDLE) && sync;
    // The ack cycle blocks acceptance so a held strobe is taken only once
    w_accept       = (r_state == c_LOAD) && sync && stb_i && !r_ack;
    w_last         = w_accept && (r_wr_ptr == c_LAST_IDX);
    w_abort        = (r_state == c_LOAD) && !sync;
    w_stream_start = (r_state == c_DONE) && !sync;
    w_reload       = (r_state == c_STREAM) && sync;
    w_advance      = (r_state == c_STREAM) && !sync && r_stb && ack_i;
    if (w_stream_start || (r_rd_ptr == c_LAST_IDX)) begin
      w_rd_nxt = 4'd0;
    end else begin
      w_rd_nxt = r_rd_ptr + 4'd1;
    end
  end

  // Read mux: byte that data_o will present after the next edge
  always_comb begin
    w_rd_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (w_rd_nxt == 4'(i)) begin
        w_rd_byte = w_cfg_flat[i*8 +: 8];
      end
    end
  end

  // Configuration register file, one byte register per entry
  generate
    for (genvar i = 0; i < NBYTES; i++) begin : g_cfg
      logic [7:0] r_byte;

      // Capture the accepted byte when the write pointer selects this entry
      always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
          r_byte <= 8'h00;
        end else if (w_accept && (r_wr_ptr == 4'(i))) begin
          r_byte <= data_i;
        end
      end

      assign w_cfg_flat[i*8 +: 8] = r_byte;
    end
  endgenerate

  // Pointers, handshake and status registers
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_wr_ptr    <= 4'd0;
      r_rd_ptr    <= 4'd0;
      r_ack       <= 1'b0;
      r_stb       <= 1'b0;
      r_data      <= 8'h00;
      r_cfg_valid <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_ack <= w_accept;

      if (w_load_start || w_reload) begin
        r_wr_ptr <= 4'd0;
      end else if (w_accept) begin
        r_wr_ptr <= w_last ? 4'd0 : (r_wr_ptr + 4'd1);
      end

      if (w_reload) begin
        r_cfg_valid <= 1'b0;
      end else if (w_last) begin
        r_cfg_valid <= 1'b1;
      end

      if (w_abort) begin
        r_load_err <= 1'b1;
      end else if (w_last) begin
        r_load_err <= 1'b0;
      end

      // Stream entry preloads cfg[0]; a reload drops the stream, ignoring ack_i
      if (w_stream_start) begin
        r_rd_ptr <= 4'd0;
        r_stb    <= 1'b1;
        r_data   <= w_rd_byte;
      end else if (w_reload) begin
        r_stb    <= 1'b0;
      end else if (w_advance) begin
        r_rd_ptr <= w_rd_nxt;
        r_data   <= w_rd_byte;
      end
    end
  end

  assign ack_o     = r_ack;
  assign stb_o     = r_stb;
  assign data_o    = r_data;
  assign cfg_valid = r_cfg_valid;
  assign load_err  = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_ppu_cfg_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ppu_cfg_rx
//  Description : Directed self-checking bench for ppu_cfg_rx.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ppu_cfg_rx;

  localparam int NB = 10;

  logic       clk_pix = 1'b0;
  logic       rst_pix;
  logic       sync;
  logic [7:0] data_i;
  logic       stb_i;
  logic       ack_o;
  logic [7:0] data_o;
  logic       stb_o;
  logic       ack_i;
  logic       cfg_valid;
  logic       load_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] nom  [NB] = '{8'd42, 8'd123, 8'd87, 8'd255, 8'd0,
                            8'd198, 8'd76, 8'd34, 8'd210, 8'hB6};
  logic [7:0] exp2 [NB] = '{8'h2A, 8'h2A, 8'h2A, 8'h11, 8'h12,
                            8'h13, 8'h14, 8'h15, 8'h16, 8'h17};

  ppu_cfg_rx #(.NBYTES(NB)) dut (
    .clk_pix   (clk_pix),
    .rst_pix   (rst_pix),
    .sync      (sync),
    .data_i    (data_i),
    .stb_i     (stb_i),
    .ack_o     (ack_o),
    .data_o    (data_o),
    .stb_o     (stb_o),
    .ack_i     (ack_i),
    .cfg_valid (cfg_valid),
    .load_err  (load_err)
  );

  always #5 clk_pix = ~clk_pix;

  // Advance one clock and land 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte, holding it through the previous ack cycle, and wait for ack
  task automatic send_byte(input logic [7:0] b, input string tag);
    int n;
    if (ack_o === 1'b1) tick();
    stb_i  = 1'b1;
    data_i = b;
    n = 0;
    tick();
    while (ack_o !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk(tag, 32'(ack_o), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_pix = 1'b1; sync = 1'b0; data_i = 8'h00; stb_i = 1'b0; ack_i = 1'b0;
    tick(); tick();
    chk("rst_ack",   32'(ack_o),     32'd0);
    chk("rst_stb",   32'(stb_o),     32'd0);
    chk("rst_data",  32'(data_o),    32'd0);
    chk("rst_valid", 32'(cfg_valid), 32'd0);
    chk("rst_err",   32'(load_err),  32'd0);
    rst_pix = 1'b0;

    // Nominal load of ten bytes
    sync = 1'b1;
    tick();
    for (int i = 0; i < NB; i++) begin
      if (i == NB - 1) chk("nom_valid_before_last", 32'(cfg_valid), 32'd0);
      send_byte(nom[i], "nom_ack");
    end
    chk("nom_valid_after_last", 32'(cfg_valid), 32'd1);
    chk("nom_err", 32'(load_err), 32'd0);
    // DONE ignores the still-held strobe
    tick(); chk("done_no_ack0", 32'(ack_o), 32'd0);
    tick(); chk("done_no_ack1", 32'(ack_o), 32'd0);
    chk("done_stb", 32'(stb_o), 32'd0);

    // Stream with continuous ack_i, including wrap
    sync = 1'b0; stb_i = 1'b0;
    tick();
    chk("str_stb",   32'(stb_o),  32'd1);
    chk("str_data0", 32'(data_o), 32'(nom[0]));
    ack_i = 1'b1;
    for (int k = 1; k <= NB; k++) begin
      tick();
      chk("str_data", 32'(data_o), 32'(nom[k % NB]));
    end
    ack_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("str_hold", 32'(data_o), 32'(nom[0]));
      chk("str_hold_stb", 32'(stb_o), 32'd1);
    end

    // Reload mid-stream with a coincident ack_i
    sync = 1'b1; ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    chk("reload_stb",   32'(stb_o),     32'd0);
    chk("reload_valid", 32'(cfg_valid), 32'd0);

    // Held strobe for six cycles: accepts alternate with ack pulses
    stb_i = 1'b1; data_i = 8'h2A;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("held_ack", 32'(ack_o), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    for (int i = 3; i < NB; i++) send_byte(exp2[i], "held_rest_ack");
    chk("held_valid", 32'(cfg_valid), 32'd1);

    // Stream the reloaded set: three 0x2A then the new bytes
    sync = 1'b0; stb_i = 1'b0;
    tick();
    chk("str2_data0", 32'(data_o), 32'(exp2[0]));
    ack_i = 1'b1;
    for (int k = 1; k < NB; k++) begin
      tick();
      chk("str2_data", 32'(data_o), 32'(exp2[k]));
    end
    ack_i = 1'b0;

    // Short load: four bytes then sync drops alongside a live strobe
    sync = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send_byte(8'(8'h50 + i), "short_ack");
    data_i = 8'h99;
    tick();
    chk("short_gap_ack", 32'(ack_o), 32'd0);
    sync = 1'b0;
    tick();
    chk("abort_no_ack", 32'(ack_o),     32'd0);
    chk("abort_err",    32'(load_err),  32'd1);
    chk("abort_valid",  32'(cfg_valid), 32'd0);
    chk("abort_stb",    32'(stb_o),     32'd0);
    stb_i = 1'b0;
    tick(); tick();
    chk("idle_stb",     32'(stb_o),     32'd0);
    chk("idle_err",     32'(load_err),  32'd1);

    // Full load after the short one clears load_err
    sync = 1'b1;
    tick();
    chk("load_err_sticky", 32'(load_err), 32'd1);
    for (int i = 0; i < NB; i++) send_byte(8'(i * 3 + 5), "full_ack");
    chk("full_err",   32'(load_err),  32'd0);
    chk("full_valid", 32'(cfg_valid), 32'd1);
    stb_i = 1'b0; ack_i = 1'b1;
    tick();
    chk("done_ack_i_stb", 32'(stb_o), 32'd0);
    sync = 1'b0;
    tick();
    ack_i = 1'b0;
    chk("full_str_stb",   32'(stb_o),  32'd1);
    chk("full_str_data0", 32'(data_o), 32'd5);

    // Reset in the middle of a load after three bytes
    sync = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) send_byte(8'(8'hC0 + i), "mid_ack");
    rst_pix = 1'b1;
    tick();
    chk("mrst_ack",   32'(ack_o),     32'd0);
    chk("mrst_stb",   32'(stb_o),     32'd0);
    chk("mrst_data",  32'(data_o),    32'd0);
    chk("mrst_valid", 32'(cfg_valid), 32'd0);
    chk("mrst_err",   32'(load_err),  32'd0);
    chk("mrst_cfg_zero", 32'(dut.w_cfg_flat == '0), 32'd1);
    rst_pix = 1'b0; stb_i = 1'b0;
    tick();
    for (int i = 0; i < NB; i++) send_byte(8'(i * 17 + 1), "restart_ack");
    chk("restart_valid", 32'(cfg_valid), 32'd1);
    sync = 1'b0; stb_i = 1'b0;
    tick();
    chk("restart_data0", 32'(data_o), 32'd1);
    ack_i = 1'b1;
    tick();
    chk("restart_data1", 32'(data_o), 32'd18);
    ack_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
